// File: rtl/alu_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller: tracks EX/MEM/WB destinations, produces
// operand forwarding selects, load-use stall, EX bubbles and the WB register-file write port.
module alu_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_dec,
  input  logic [REG_W-1:0] ra_dec,
  input  logic [REG_W-1:0] rb_dec,
  input  logic             use_a_dec,
  input  logic             use_b_dec,
  input  logic [REG_W-1:0] RW_dec,
  input  logic             we_dec,
  input  logic             mem_mux_sel_dec,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             valid_ex,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [CNT_W-1:0] stall_cnt
);

  // Stage entries: _p0 = EX, _p1 = MEM, _p2 = WB. The load flag only matters in EX
  // (load-use detection and the EX forward path), so it is not carried further.
  logic             vld_p0, we_p0, ld_p0;
  logic [REG_W-1:0] rw_p0;
  logic             vld_p1, we_p1;
  logic [REG_W-1:0] rw_p1;
  logic             vld_p2, we_p2;
  logic [REG_W-1:0] rw_p2;

  logic ex_hit_a, mem_hit_a, wb_hit_a;
  logic ex_hit_b, mem_hit_b, wb_hit_b;
  logic lu;

  function automatic logic hit(input logic v, input logic we,
                               input logic [REG_W-1:0] rw, input logic [REG_W-1:0] r);
    return v & we & (rw == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_enc(input logic use_r, input logic ex_h, input logic ex_ld,
                                         input logic mem_h, input logic wb_h);
    if (!use_r)              return 2'b00;
    else if (ex_h && !ex_ld) return 2'b01;
    else if (mem_h)          return 2'b10;
    else if (wb_h)           return 2'b11;
    else                     return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    ex_hit_a  = hit(vld_p0, we_p0, rw_p0, ra_dec);
    mem_hit_a = hit(vld_p1, we_p1, rw_p1, ra_dec);
    wb_hit_a  = hit(vld_p2, we_p2, rw_p2, ra_dec);
    ex_hit_b  = hit(vld_p0, we_p0, rw_p0, rb_dec);
    mem_hit_b = hit(vld_p1, we_p1, rw_p1, rb_dec);
    wb_hit_b  = hit(vld_p2, we_p2, rw_p2, rb_dec);
    fwd_a     = fwd_enc(use_a_dec, ex_hit_a, ld_p0, mem_hit_a, wb_hit_a);
    fwd_b     = fwd_enc(use_b_dec, ex_hit_b, ld_p0, mem_hit_b, wb_hit_b);
    lu        = valid_dec & ld_p0 & ((use_a_dec & ex_hit_a) | (use_b_dec & ex_hit_b));
    stall     = mem_busy | (lu & ~flush);
  end

  assign valid_ex = vld_p0;
  assign rf_we    = vld_p2 & we_p2;
  assign rf_waddr = rw_p2;

  // Decode -> EX -> MEM -> WB; everything freezes while memory is busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0; we_p0 <= 1'b0; ld_p0 <= 1'b0; rw_p0 <= '0;
      vld_p1 <= 1'b0; we_p1 <= 1'b0; rw_p1 <= '0;
      vld_p2 <= 1'b0; we_p2 <= 1'b0; rw_p2 <= '0;
      stall_cnt <= '0;
    end else if (!mem_busy) begin
      vld_p2 <= vld_p1; we_p2 <= we_p1; rw_p2 <= rw_p1;
      vld_p1 <= vld_p0; we_p1 <= we_p0; rw_p1 <= rw_p0;
      if (flush || lu || !valid_dec) begin
        vld_p0 <= 1'b0; we_p0 <= 1'b0; ld_p0 <= 1'b0; rw_p0 <= '0;
      end else begin
        vld_p0 <= 1'b1; we_p0 <= we_dec; ld_p0 <= mem_mux_sel_dec; rw_p0 <= RW_dec;
      end
      if (lu && !flush) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_alu_hazard_ctrl.sv
// Bench for alu_hazard_ctrl: in-flight instruction model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_alu_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid_dec = 0, use_a_dec = 0, use_b_dec = 0, we_dec = 0, mem_mux_sel_dec = 0;
  logic flush = 0, mem_busy = 0;
  logic [REG_W-1:0] ra_dec = '0, rb_dec = '0, RW_dec = '0;
  logic stall, valid_ex, rf_we;
  logic [1:0] fwd_a, fwd_b;
  logic [REG_W-1:0] rf_waddr;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  alu_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_dec(valid_dec), .ra_dec(ra_dec), .rb_dec(rb_dec),
    .use_a_dec(use_a_dec), .use_b_dec(use_b_dec), .RW_dec(RW_dec), .we_dec(we_dec),
    .mem_mux_sel_dec(mem_mux_sel_dec), .flush(flush), .mem_busy(mem_busy),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .valid_ex(valid_ex), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: m_*[0] is the youngest in-flight instruction (EX), [2] the oldest (WB).
  logic             m_v[3], m_we[3], m_ld[3];
  logic [REG_W-1:0] m_rw[3];
  int               m_cnt;

  function automatic int m_fwd(input logic [REG_W-1:0] r, input logic use_r);
    if (!use_r || r == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (m_v[i] && m_we[i] && m_rw[i] == r && !(i == 0 && m_ld[i])) return i + 1;
    return 0;
  endfunction

  function automatic logic m_lu();
    if (!valid_dec || !m_v[0] || !m_we[0] || !m_ld[0] || m_rw[0] == 0) return 1'b0;
    return (use_a_dec && ra_dec == m_rw[0]) || (use_b_dec && rb_dec == m_rw[0]);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_rw[i] = 0;
      end
      m_cnt = 0;
    end else if (!mem_busy) begin
      logic lu;
      lu = m_lu();
      if (lu && !flush && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1]; m_rw[i] = m_rw[i-1];
      end
      if (flush || lu || !valid_dec) begin
        m_v[0] = 0; m_we[0] = 0; m_ld[0] = 0; m_rw[0] = 0;
      end else begin
        m_v[0] = 1; m_we[0] = we_dec; m_ld[0] = mem_mux_sel_dec; m_rw[0] = RW_dec;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", stall, mem_busy || (m_lu() && !flush));
    chk("fwd_a", fwd_a, m_fwd(ra_dec, use_a_dec));
    chk("fwd_b", fwd_b, m_fwd(rb_dec, use_b_dec));
    chk("valid_ex", valid_ex, m_v[0]);
    chk("rf_we", rf_we, m_v[2] && m_we[2]);
    chk("rf_waddr", rf_waddr, m_rw[2]);
    chk("stall_cnt", stall_cnt, m_cnt);
  end

  task automatic drive(input logic v, input int ra, input int rb, input logic ua, input logic ub,
                       input int rw, input logic we, input logic ld, input logic fl, input logic mb);
    valid_dec = v; ra_dec = REG_W'(ra); rb_dec = REG_W'(rb); use_a_dec = ua; use_b_dec = ub;
    RW_dec = REG_W'(rw); we_dec = we; mem_mux_sel_dec = ld; flush = fl; mem_busy = mb;
    #3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    #2;
    chk("reset_valid_ex", valid_ex, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    tick(); tick();
    reset = 1'b1;
    idle(1);

    // ALU producer, then consumers at distance 1..4
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    chk("alu_p_stall", stall, 0);
    tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    chk("d1_fwd_a", fwd_a, 1); chk("d1_fwd_b", fwd_b, 1); chk("d1_stall", stall, 0);
    tick();
    drive(1, 5, 0, 1, 0, 7, 1, 0, 0, 0);
    chk("d2_fwd_a", fwd_a, 2);
    tick();
    drive(1, 5, 0, 1, 0, 8, 1, 0, 0, 0);
    chk("d3_fwd_a", fwd_a, 3);
    tick();
    drive(1, 5, 0, 1, 0, 9, 1, 0, 0, 0);
    chk("d4_fwd_a", fwd_a, 0);
    tick();

    // Load-use: one stall cycle with bubble, then MEM forward
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
    tick();
    drive(1, 0, 10, 0, 1, 11, 1, 0, 0, 0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", valid_ex, 0);
    chk("lu_fwd_b", fwd_b, 2);
    chk("lu_stall_after", stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    tick();

    // Register 0 never forwards or stalls, even from a load
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 1, 0, 4, 1, 0, 0, 0);
    chk("r0_fwd_a", fwd_a, 0); chk("r0_stall", stall, 0);
    tick();

    // Flush masks a load-use hazard
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    tick();
    drive(1, 12, 0, 1, 0, 13, 1, 0, 1, 0);
    chk("fl_stall", stall, 0);
    tick();
    chk("fl_bubble", valid_ex, 0);
    chk("fl_cnt", stall_cnt, 1);

    // mem_busy freeze with a load in MEM
    idle(3);
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(0, 10, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mb_stall", stall, 1);
      chk("mb_fwd_a", fwd_a, 2);
      chk("mb_rf_we", rf_we, 0);
      chk("mb_rf_waddr", rf_waddr, 0);
      chk("mb_valid_ex", valid_ex, 1);
      tick();
      #3;
    end
    drive(0, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("mb_rel_fwd_a", fwd_a, 2);
    chk("mb_rel_stall", stall, 0);
    tick();
    chk("mb_wb_we", rf_we, 1);
    chk("mb_wb_addr", rf_waddr, 10);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic mb, fl;
      mb = ($urandom_range(0, 7) == 0);
      fl = !mb && ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, fl, mb);
      tick();
    end

    // Counter saturation: enough load-use events to exceed the counter range
    for (int n = 0; n < 18; n++) begin
      drive(1, 0, 0, 0, 0, 20, 1, 1, 0, 0);
      tick();
      drive(1, 20, 0, 1, 0, 21, 1, 0, 0, 0);
      tick(); tick();
    end
    chk("sat_cnt", stall_cnt, (1 << CNT_W) - 1);

    // Asynchronous reset with the pipeline full
    drive(1, 0, 0, 0, 0, 22, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 23, 1, 0, 0, 0); tick();
    drive(1, 22, 23, 1, 1, 24, 1, 0, 0, 0);
    chk("pre_rst_valid_ex", valid_ex, 1);
    reset = 1'b0;
    #1;
    chk("arst_valid_ex", valid_ex, 0);
    chk("arst_rf_we", rf_we, 0);
    chk("arst_rf_waddr", rf_waddr, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_fwd_a", fwd_a, 0);
    chk("arst_fwd_b", fwd_b, 0);
    chk("arst_stall", stall, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
